// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD encoder.
// The optional DIV4_FLAG_EN build adds a divisible-by-4 result flag.
package bcd_pkg;
  localparam int BIN_W        = 7;
  localparam int DIGIT_W      = 4;
  localparam int SHIFT_CYCLES = 7;
  localparam int NUM_DIGITS   = 3;
  localparam int BCD_W        = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W        = 3;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_adj3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= digit_t'(5)) ? din + digit_t'(3) : din;

endmodule

// File: rtl/bcd_encoder.sv
// Sequential 7-bit binary to two-digit BCD encoder (double-dabble, MSB first).
// Define DIV4_FLAG_EN to add the Divisible output.
module bcd_encoder
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DIGIT_W-1:0] YT,
  output logic [DIGIT_W-1:0] YO,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DIV4_FLAG_EN
  ,
  output logic             Divisible
`endif
);

  state_t             state_reg, state_next;
  logic [BIN_W-1:0]   bin_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;
  logic               shift_done;

  // Digit order in bcd_reg: ones at the bottom, hundreds at the top.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      bcd_adj3 u_adj3 (
        .din  (bcd_reg[gi*DIGIT_W +: DIGIT_W]),
        .dout (bcd_adj[gi*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  // The carry out of the hundreds digit is always zero for a 7-bit input.
  assign bcd_shift  = BCD_W'({bcd_adj, bin_reg[BIN_W-1]});
  assign shift_done = (cnt_reg == CNT_W'(SHIFT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (shift_done) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_reg <= '0;
      cnt_reg <= '0;
      bcd_reg <= '0;
    end else if (state_reg == IDLE && in_valid) begin
      bin_reg <= bin;
      cnt_reg <= '0;
      bcd_reg <= '0;
    end else if (state_reg == SHIFT && !shift_done) begin
      bin_reg <= {bin_reg[BIN_W-2:0], 1'b0};
      cnt_reg <= cnt_reg + CNT_W'(1);
      bcd_reg <= bcd_shift;
    end
  end

  assign YO       = bcd_reg[0*DIGIT_W +: DIGIT_W];
  assign YT       = bcd_reg[1*DIGIT_W +: DIGIT_W];
  assign overflow = |bcd_reg[2*DIGIT_W +: DIGIT_W];

`ifdef DIV4_FLAG_EN
  logic div_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg <= 1'b0;
    end else if (state_reg == IDLE && in_valid) begin
      div_reg <= (bin[1:0] == 2'b00);
    end
  end

  assign Divisible = div_reg;
`endif

endmodule

// File: tb/tb_bcd_encoder.sv
// Directed and exhaustive self-checking bench for bcd_encoder.
module tb_bcd_encoder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] bin = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic [3:0] YT;
  logic [3:0] YO;
  logic       overflow;
  logic       out_valid;
`ifdef DIV4_FLAG_EN
  logic       Divisible;
`endif

  int tests = 0;
  int fails = 0;

  bcd_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .YT        (YT),
    .YO        (YO),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DIV4_FLAG_EN
    ,
    .Divisible (Divisible)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept v and wait (bounded) for out_valid; lat counts edges after the accepting edge.
  task automatic do_conv(input logic [6:0] v, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    bin = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    bin = 7'h55;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    $display("[TB] bin=%0d -> YT=%0d YO=%0d overflow=%0d latency=%0d", v, YT, YO, overflow, lat);
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (YT !== 4'd0) begin fails++; $display("FAIL reset_YT got=%0d exp=0", YT); end
    tests++; if (YO !== 4'd0) begin fails++; $display("FAIL reset_YO got=%0d exp=0", YO); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
`ifdef DIV4_FLAG_EN
    tests++; if (Divisible !== 1'b0) begin fails++; $display("FAIL reset_Divisible got=%b exp=0", Divisible); end
`endif
  endtask

  task automatic test_zero;
    int lat;
    do_conv(7'd0, lat);
    tests++; if (lat !== 8) begin fails++; $display("FAIL zero_latency got=%0d exp=8", lat); end
    tests++; if (YT !== 4'd0 || YO !== 4'd0) begin fails++; $display("FAIL zero_digits got=%0d/%0d exp=0/0", YT, YO); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL zero_overflow got=%b exp=0", overflow); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL zero_in_ready_in_done got=%b exp=0", in_ready); end
`ifdef DIV4_FLAG_EN
    tests++; if (Divisible !== 1'b1) begin fails++; $display("FAIL zero_Divisible got=%b exp=1", Divisible); end
`endif
    release_out();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL zero_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_values;
    logic [6:0] vals [3];
    logic [3:0] et   [3];
    logic [3:0] eo   [3];
    logic       ed   [3];
    int lat;
    vals = '{7'd37, 7'd99, 7'd40};
    et   = '{4'd3, 4'd9, 4'd4};
    eo   = '{4'd7, 4'd9, 4'd0};
    ed   = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      do_conv(vals[i], lat);
      tests++; if (lat !== 8) begin fails++; $display("FAIL values_latency bin=%0d got=%0d exp=8", vals[i], lat); end
      tests++; if (YT !== et[i] || YO !== eo[i]) begin fails++; $display("FAIL values_digits bin=%0d got=%0d/%0d exp=%0d/%0d", vals[i], YT, YO, et[i], eo[i]); end
      tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL values_overflow bin=%0d got=%b exp=0", vals[i], overflow); end
`ifdef DIV4_FLAG_EN
      tests++; if (Divisible !== ed[i]) begin fails++; $display("FAIL values_Divisible bin=%0d got=%b exp=%b", vals[i], Divisible, ed[i]); end
`else
      if (ed[i]) ed[i] = 1'b0;
`endif
      release_out();
    end
  endtask

  task automatic test_overflow;
    int lat;
    do_conv(7'd127, lat);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf127_overflow got=%b exp=1", overflow); end
    tests++; if (YT !== 4'd2 || YO !== 4'd7) begin fails++; $display("FAIL ovf127_digits got=%0d/%0d exp=2/7", YT, YO); end
    release_out();
    do_conv(7'd100, lat);
    tests++; if (overflow !== 1'b1 || YT !== 4'd0 || YO !== 4'd0) begin fails++; $display("FAIL ovf100 got ovf=%b %0d/%0d exp ovf=1 0/0", overflow, YT, YO); end
    release_out();
  endtask

  task automatic test_stall;
    int lat;
    do_conv(7'd52, lat);
    tests++; if (lat !== 8) begin fails++; $display("FAIL stall_latency got=%0d exp=8", lat); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      bin = 7'd13;
      tick();
      tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL stall_hs cycle=%0d got ov=%b ir=%b exp ov=1 ir=0", i, out_valid, in_ready); end
      tests++; if (YT !== 4'd5 || YO !== 4'd2 || overflow !== 1'b0) begin fails++; $display("FAIL stall_hold cycle=%0d got %0d/%0d ovf=%b exp 5/2 ovf=0", i, YT, YO, overflow); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL stall_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stall_no_same_cycle_accept got ir=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back;
    int lat;
    do_conv(7'd88, lat);
    release_out();
    do_conv(7'd21, lat);
    tests++; if (lat !== 8 || YT !== 4'd2 || YO !== 4'd1) begin fails++; $display("FAIL b2b got lat=%0d %0d/%0d exp lat=8 2/1", lat, YT, YO); end
    release_out();
  endtask

  task automatic test_reset_mid;
    int lat;
    bin = 7'd99;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    in_valid = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_state got ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid); end
    tests++; if (YT !== 4'd0 || YO !== 4'd0) begin fails++; $display("FAIL rstmid_digits got=%0d/%0d exp=0/0", YT, YO); end
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_priority got ir=%b exp=1", in_ready); end
    do_conv(7'd64, lat);
    tests++; if (lat !== 8 || YT !== 4'd6 || YO !== 4'd4) begin fails++; $display("FAIL rstmid_after got lat=%0d %0d/%0d exp lat=8 6/4", lat, YT, YO); end
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || YT !== 4'd0 || YO !== 4'd0) begin fails++; $display("FAIL rstdone got ov=%b %0d/%0d exp ov=0 0/0", out_valid, YT, YO); end
  endtask

  task automatic test_sweep;
    int lat;
    int exp_mod;
    int sweep_fails;
    sweep_fails = 0;
    for (int v = 0; v < 128; v++) begin
      do_conv(7'(v), lat);
      exp_mod = v % 100;
      tests++;
      if (lat !== 8 || YT > 4'd9 || YO > 4'd9 || (int'(YT) * 10 + int'(YO)) !== exp_mod || overflow !== (v > 99)) begin
        fails++;
        sweep_fails++;
        $display("FAIL sweep bin=%0d got lat=%0d %0d/%0d ovf=%b exp lat=8 value=%0d ovf=%b", v, lat, YT, YO, overflow, exp_mod, (v > 99));
      end
      release_out();
    end
    $display("[TB] sweep done, %0d sweep failures", sweep_fails);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_overflow();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
